// File: rtl/serial_subtracter_ctrl_pkg.sv
// Shared types and defaults for the bit-serial subtracter.
package serial_subtracter_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtracter_cell.sv
// Single-bit full subtracter: x - y - z with borrow out.
module full_subtracter_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic difference,
  output logic borrow
);

  assign difference = x ^ y ^ z;
  assign borrow     = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtracter_ctrl.sv
// Bit-serial WIDTH-bit subtracter: one bit pair per clock through a single cell, LSB first.
module serial_subtracter_ctrl
  import serial_subtracter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_d;
  logic cell_bo;

  full_subtracter_cell u_cell (
    .x          (a_sr_q[0]),
    .y          (b_sr_q[0]),
    .z          (brw_q),
    .difference (cell_d),
    .borrow     (cell_bo)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bo_d    = bo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = borrow_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        brw_d  = cell_bo;
        // Counter stops at WIDTH-1 so it never wraps by overflow
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = res_d;
          bo_d    = cell_bo;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtracter_ctrl.sv
// Directed and swept checks of serial_subtracter_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_subtracter_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  logic        start8, bin8, busy8, done8, bo8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, bin13, busy13, done13, bo13;
  logic [12:0] a13, b13, diff13;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtracter_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .borrow_in  (bin8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8)
  );

  serial_subtracter_ctrl #(.WIDTH(13)) dut13 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start13),
    .a          (a13),
    .b          (b13),
    .borrow_in  (bin13),
    .busy       (busy13),
    .done       (done13),
    .diff       (diff13),
    .borrow_out (bo13)
  );

  // Launch one operation from IDLE; edges counts clock edges from the accept edge up to done.
  task automatic run_op(input bit w13, input logic [31:0] av, input logic [31:0] bv,
                        input logic bin, output logic [31:0] d, output logic bo,
                        output int edges);
    if (w13) begin
      a13 = av[12:0]; b13 = bv[12:0]; bin13 = bin; start13 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; bin8 = bin; start8 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    start13 = 1'b0;
    edges = 1;
    while (!(w13 ? done13 : done8) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 40) edges = -1;
    d  = w13 ? 32'(diff13) : 32'(diff8);
    bo = w13 ? bo13 : bo8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
    total++; if (diff8 !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h exp=00", diff8); end
    total++; if (bo8 !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", bo8); end
    total++; if (busy13 !== 1'b0 || done13 !== 1'b0 || diff13 !== 13'h0)
      begin bad++; $display("FAIL reset_w13 got busy=%b done=%b diff=%h exp 0/0/0", busy13, done13, diff13); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic bo; int e;
    run_op(1'b0, 32'h5A, 32'h3C, 1'b0, d, bo, e);
    total++; if (e !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", e); end
    total++; if (d[7:0] !== 8'h1E) begin bad++; $display("FAIL basic_diff got=%h exp=1e", d[7:0]); end
    total++; if (bo !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b exp=0", bo); end
  endtask

  task automatic test_boundaries();
    logic [31:0] d; logic bo; int e;
    run_op(1'b0, 32'h00, 32'h01, 1'b0, d, bo, e);
    total++; if (d[7:0] !== 8'hFF) begin bad++; $display("FAIL under_diff got=%h exp=ff", d[7:0]); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL under_borrow got=%b exp=1", bo); end
    run_op(1'b0, 32'h80, 32'h80, 1'b1, d, bo, e);
    total++; if (d[7:0] !== 8'hFF) begin bad++; $display("FAIL eq_bin_diff got=%h exp=ff", d[7:0]); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL eq_bin_borrow got=%b exp=1", bo); end
    run_op(1'b0, 32'hFF, 32'h00, 1'b1, d, bo, e);
    total++; if (d[7:0] !== 8'hFE || bo !== 1'b0)
      begin bad++; $display("FAIL max_bin got=%h/%b exp=fe/0", d[7:0], bo); end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [7:0] got = 8'h00;
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    for (int n = 0; n < 25; n++) begin
      if (done8) begin
        dones++;
        got = diff8;
        start8 = 1'b1;
      end else begin
        start8 = (n == 2);
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++; if (got !== 8'h0F) begin bad++; $display("FAIL ignore_diff got=%h exp=0f", got); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ignore_idle_busy got=%b exp=0", busy8); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int prev = -1;
    a8 = 8'h07; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 30; n++) begin
      if (done8) begin
        dones++;
        total++; if (diff8 !== 8'h04) begin bad++; $display("FAIL b2b_diff got=%h exp=04", diff8); end
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_busy_in_done got=%b exp=1", busy8); end
        if (prev >= 0) begin
          total++;
          if (n - prev !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d exp=10", n - prev); end
        end
        prev = n;
      end
      if (n == 29) start8 = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (dones !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", dones); end
  endtask

  task automatic test_abort();
    int dones = 0;
    logic [31:0] d; logic bo; int e;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done8); end
    total++; if (diff8 !== 8'h00) begin bad++; $display("FAIL abort_diff got=%h exp=00", diff8); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    run_op(1'b0, 32'h02, 32'h03, 1'b0, d, bo, e);
    total++; if (d[7:0] !== 8'hFF || bo !== 1'b1 || e !== 9)
      begin bad++; $display("FAIL abort_restart got=%h/%b/%0d exp=ff/1/9", d[7:0], bo, e); end
  endtask

  task automatic test_random_w8();
    logic [31:0] av, bv, d; logic bin, bo; int e;
    logic [8:0] exp9;
    for (int i = 0; i < 300; i++) begin
      av = $urandom & 32'hFF; bv = $urandom & 32'hFF; bin = 1'($urandom_range(1));
      run_op(1'b0, av, bv, bin, d, bo, e);
      exp9 = {1'b0, av[7:0]} - {1'b0, bv[7:0]} - 9'(bin);
      total++;
      if (e !== 9 || d[7:0] !== exp9[7:0] || bo !== exp9[8]) begin
        bad++;
        $display("FAIL rand_w8 a=%h b=%h bin=%b got=%h/%b/%0d exp=%h/%b/9",
                 av[7:0], bv[7:0], bin, d[7:0], bo, e, exp9[7:0], exp9[8]);
      end
    end
  endtask

  task automatic test_random_w13();
    logic [31:0] av, bv, d; logic bin, bo; int e;
    logic [13:0] exp14;
    for (int i = 0; i < 200; i++) begin
      av = $urandom & 32'h1FFF; bv = $urandom & 32'h1FFF; bin = 1'($urandom_range(1));
      run_op(1'b1, av, bv, bin, d, bo, e);
      exp14 = {1'b0, av[12:0]} - {1'b0, bv[12:0]} - 14'(bin);
      total++;
      if (e !== 14 || d[12:0] !== exp14[12:0] || bo !== exp14[13]) begin
        bad++;
        $display("FAIL rand_w13 a=%h b=%h bin=%b got=%h/%b/%0d exp=%h/%b/14",
                 av[12:0], bv[12:0], bin, d[12:0], bo, e, exp14[12:0], exp14[13]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random_w8();
    test_random_w13();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
